audio_nios_sd_dat_in: RTL and testbench

Avalon-MM slave input port that samples the bit-banged SD card DAT/CMD return lines into the Nios II. It is the receive-side counterpart of the SD clock/command output ports: software drives the SD clock through the output PIO and reads the card's response lines here. The block synchronises the asynchronous pins, exposes their level, latches edges into a sticky capture register and raises a maskable interrupt.

---
 rtl/audio_nios_sd_dat_in.sv | 99 +++++++++
 tb/tb_audio_nios_sd_dat_in.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/audio_nios_sd_dat_in.sv
// Avalon-MM input port for the bit-banged SD card DAT/CMD return lines.
// Synchronises the pins, exposes their level, latches edges stickily and raises a maskable irq.
module audio_nios_sd_dat_in #(
  parameter int WIDTH     = 4,
  parameter int EDGE_TYPE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Bus handshake: a write is accepted on any rising clk edge where chipselect is
  // high and write_n is low; reads have no waitrequest and a fixed latency of one cycle.

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_CAP  = 2'd3;

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [1:0]       warm_q, warm_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_bits;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect & ~write_n;
  assign wr_bits      = writedata[WIDTH-1:0];

  always_comb begin
    edge_raw = s2_q ^ prev_q;
    if (EDGE_TYPE == 0) begin
      edge_raw = s2_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_raw = ~s2_q & prev_q;
    end
    // Zero-reset flops filling with pulled-up levels look like edges until warm-up ends.
    edge_det = (warm_q == 2'd3) ? edge_raw : '0;
  end

  always_comb begin
    s1_d     = in_port;
    s2_d     = s1_q;
    prev_d   = s2_q;
    warm_d   = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    clr_bits = (wr_en && address == ADDR_CAP) ? wr_bits : '0;
    // Set is OR-ed in after the clear so a simultaneous edge is never lost.
    cap_d    = (cap_q & ~clr_bits) | edge_det;
    mask_d   = (wr_en && address == ADDR_MASK) ? wr_bits : mask_q;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = s2_q;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_CAP:  readdata_d[WIDTH-1:0] = cap_q;
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      mask_q     <= '0;
      cap_q      <= '0;
      warm_q     <= 2'd0;
      readdata_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      prev_q     <= prev_d;
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      warm_q     <= warm_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_audio_nios_sd_dat_in.sv
// Directed bench for audio_nios_sd_dat_in: falling-edge default instance plus an any-edge instance.
module tb_audio_nios_sd_dat_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [3:0]  in_port_b;
  logic [31:0] readdata;
  logic [31:0] readdata_b;
  logic        irq;
  logic        irq_b;

  int tests_run;
  int tests_failed;

  audio_nios_sd_dat_in #(.WIDTH(4), .EDGE_TYPE(1)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  audio_nios_sd_dat_in #(.WIDTH(4), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port_b),
    .readdata(readdata_b), .irq(irq_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    chipselect = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    address      = 2'd0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    writedata    = '0;
    in_port      = 4'hF;
    in_port_b    = 4'h0;

    // reset with pins high, no false captures after warm-up
    ticks(3);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_readdata", readdata, 32'd0);
    reset_n = 1'b1;
    ticks(10);
    bus_read(2'd3);
    check("warm_cap_zero", readdata, 32'h0);
    bus_read(2'd0);
    check("warm_data_f", readdata, 32'hF);
    check("warm_irq", {31'd0, irq}, 32'd0);

    // falling edge on DAT0 with mask 1
    bus_write(2'd2, 32'h1);
    in_port = 4'hE;
    ticks(2);
    check("dat0_irq_early", {31'd0, irq}, 32'd0);
    tick();
    check("dat0_irq", {31'd0, irq}, 32'd1);
    bus_read(2'd3);
    check("dat0_cap", readdata, 32'h1);
    bus_write(2'd3, 32'h1);
    check("dat0_clr_irq", {31'd0, irq}, 32'd0);
    bus_read(2'd3);
    check("dat0_clr_cap", readdata, 32'h0);

    // DAT2 falling edge captured on the same edge as a clear of bit 2
    in_port = 4'hA;
    ticks(2);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3);
    check("set_wins_cap", readdata, 32'h4);
    check("set_wins_irq", {31'd0, irq}, 32'd0);
    bus_write(2'd3, 32'h4);
    bus_read(2'd3);
    check("dat2_clr_cap", readdata, 32'h0);

    // masked-off DAT3 edge, then unmask
    bus_write(2'd2, 32'h0);
    in_port = 4'h2;
    ticks(3);
    bus_read(2'd3);
    check("dat3_cap", readdata, 32'h8);
    check("dat3_irq_masked", {31'd0, irq}, 32'd0);
    bus_write(2'd2, 32'h8);
    check("dat3_unmask_irq", {31'd0, irq}, 32'd1);

    // register reads and DATA latency
    address = 2'd0;
    in_port = 4'hA;
    ticks(2);
    check("data_latency", readdata, 32'h2);
    tick();
    check("data_a", readdata, 32'h0000000A);
    bus_write(2'd0, 32'h5);
    bus_read(2'd0);
    check("data_ro", readdata, 32'h0000000A);
    bus_read(2'd1);
    check("reserved", readdata, 32'h0);
    bus_write(2'd2, 32'hFFFFFFFF);
    bus_read(2'd2);
    check("mask_f", readdata, 32'h0000000F);
    check("mask_f_irq", {31'd0, irq}, 32'd1);

    // asynchronous reset drops irq without a clock edge
    reset_n = 1'b0;
    #1;
    check("async_irq", {31'd0, irq}, 32'd0);
    check("async_readdata", readdata, 32'd0);
    ticks(2);

    // any-edge instance: edge during warm-up is lost
    reset_n   = 1'b1;
    in_port_b = 4'h1;
    ticks(8);
    bus_read(2'd3);
    check("b_warm_lost", readdata_b, 32'h0);
    bus_write(2'd2, 32'h2);

    // DAT1 rise, clear, then DAT1 fall five cycles after the rise
    in_port_b = 4'h3;
    ticks(2);
    check("b_rise_irq_early", {31'd0, irq_b}, 32'd0);
    tick();
    check("b_rise_irq", {31'd0, irq_b}, 32'd1);
    bus_read(2'd3);
    check("b_rise_cap", readdata_b, 32'h2);
    bus_write(2'd3, 32'h2);
    check("b_clr_irq", {31'd0, irq_b}, 32'd0);
    in_port_b = 4'h1;
    ticks(3);
    check("b_fall_irq", {31'd0, irq_b}, 32'd1);
    bus_read(2'd3);
    check("b_fall_cap", readdata_b, 32'h2);

    reset_n = 1'b0;
    #1;
    check("b_async_irq", {31'd0, irq_b}, 32'd0);
    ticks(2);

    // report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
